// File: rtl/pong_game_ctrl.sv
// Frame-ticked Pong game controller: paddles, ball physics, scoring and the game FSM.
// All game state advances once per frame on the registered rising edge of vsync.
module pong_game_ctrl #(
  parameter int SCR_W     = 1024,
  parameter int SCR_H     = 768,
  parameter int PAD_W     = 16,
  parameter int PAD_H     = 96,
  parameter int BALL_SZ   = 16,
  parameter int PAD_SPD   = 8,
  parameter int BALL_SPD  = 4,
  parameter int PAD1_X    = 32,
  parameter int PAD2_X    = 976,
  parameter int WIN_SCORE = 7,
  parameter int SERVE_FR  = 60
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        vsync,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] pad1_y,
  output logic [10:0] pad2_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [2:0]  state,
  output logic        frame_upd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int CW = $clog2(SERVE_FR + 1);

  localparam logic [10:0] BALL_X0  = 11'((SCR_W - BALL_SZ) / 2);
  localparam logic [10:0] BALL_Y0  = 11'((SCR_H - BALL_SZ) / 2);
  localparam logic [10:0] PAD_Y0   = 11'((SCR_H - PAD_H) / 2);
  localparam logic [10:0] PAD_YMAX = 11'(SCR_H - PAD_H);
  localparam logic [10:0] HIT_L_X  = 11'(PAD1_X + PAD_W);
  localparam logic [10:0] HIT_R_X  = 11'(PAD2_X - BALL_SZ);
  localparam logic [10:0] WALL_B_Y = 11'(SCR_H - BALL_SZ);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

  // Ball arithmetic is done signed and two bits wider so a step past 0 cannot wrap.
  localparam logic signed [12:0] K_SPD  = 13'(BALL_SPD);
  localparam logic signed [12:0] K_SZ   = 13'(BALL_SZ);
  localparam logic signed [12:0] K_PADH = 13'(PAD_H);
  localparam logic signed [12:0] K_LEDG = 13'(PAD1_X + PAD_W);
  localparam logic signed [12:0] K_REDG = 13'(PAD2_X);
  localparam logic signed [12:0] K_XMAX = 13'(SCR_W - BALL_SZ);
  localparam logic signed [12:0] K_YMAX = 13'(SCR_H - BALL_SZ);

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [10:0]     ball_x_reg, ball_x_next;
  logic [10:0]     ball_y_reg, ball_y_next;
  logic [10:0]     pad1_reg, pad1_next;
  logic [10:0]     pad2_reg, pad2_next;
  logic [3:0]      score1_reg, score1_next;
  logic [3:0]      score2_reg, score2_next;
  logic            dx_reg, dx_next;      // 1 = right
  logic            dy_reg, dy_next;      // 1 = down
  logic            scorer_reg, scorer_next; // 1 = P1 took the point
  logic            vs_q1_reg, vs_q2_reg;
  logic            frame_upd_reg;
  logic [4:0]      btn_s1_reg, btn_s2_reg;
  logic            start_q_reg;

  logic            tick;
  logic            start_rise;
  logic            p1u, p1d, p2u, p2d;
  logic            point_wins;

  logic signed [12:0] bx, by, p1s, p2s, nx, ny;
  logic               ov1, ov2, hit_l, hit_r, miss_l, miss_r;

  assign tick       = vs_q1_reg & ~vs_q2_reg;
  assign p1u        = btn_s2_reg[0];
  assign p1d        = btn_s2_reg[1];
  assign p2u        = btn_s2_reg[2];
  assign p2d        = btn_s2_reg[3];
  assign start_rise = btn_s2_reg[4] & ~start_q_reg;
  assign point_wins = ((scorer_reg ? score1_reg : score2_reg) == WIN - 4'd1);

  assign bx  = $signed({2'b00, ball_x_reg});
  assign by  = $signed({2'b00, ball_y_reg});
  assign p1s = $signed({2'b00, pad1_reg});
  assign p2s = $signed({2'b00, pad2_reg});
  assign nx  = dx_reg ? bx + K_SPD : bx - K_SPD;
  assign ny  = dy_reg ? by + K_SPD : by - K_SPD;

  // Hit tests use the paddle positions from before this frame's paddle move.
  assign ov1    = (by + K_SZ > p1s) && (by < p1s + K_PADH);
  assign ov2    = (by + K_SZ > p2s) && (by < p2s + K_PADH);
  assign hit_l  = !dx_reg && (nx <= K_LEDG) && ov1;
  assign hit_r  = dx_reg && (nx + K_SZ >= K_REDG) && ov2;
  assign miss_l = !dx_reg && (bx <= K_SPD) && !hit_l;
  assign miss_r = dx_reg && (nx >= K_XMAX) && !hit_r;

  function automatic logic [10:0] pad_step(input logic [10:0] y, input logic up, input logic dn);
    logic [10:0] r;
    r = y;
    if (up && !dn)
      r = (y < 11'(PAD_SPD)) ? 11'd0 : y - 11'(PAD_SPD);
    else if (dn && !up)
      r = (y >= PAD_YMAX - 11'(PAD_SPD)) ? PAD_YMAX : y + 11'(PAD_SPD);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_rise) state_next = S_SERVE;
      S_SERVE: if (tick && count_reg == CW'(SERVE_FR - 1)) state_next = S_PLAY;
      S_PLAY:  if (tick && (miss_l || miss_r)) state_next = S_POINT;
      S_POINT: state_next = point_wins ? S_OVER : S_SERVE;
      S_OVER:  if (start_rise) state_next = S_SERVE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next  = count_reg;
    ball_x_next = ball_x_reg;
    ball_y_next = ball_y_reg;
    pad1_next   = pad1_reg;
    pad2_next   = pad2_reg;
    score1_next = score1_reg;
    score2_next = score2_reg;
    dx_next     = dx_reg;
    dy_next     = dy_reg;
    scorer_next = scorer_reg;
    case (state_reg)
      S_IDLE: if (start_rise) count_next = '0;
      S_SERVE: if (tick) begin
        pad1_next   = pad_step(pad1_reg, p1u, p1d);
        pad2_next   = pad_step(pad2_reg, p2u, p2d);
        ball_x_next = BALL_X0;
        ball_y_next = BALL_Y0;
        count_next  = count_reg + CW'(1);
      end
      S_PLAY: if (tick) begin
        pad1_next = pad_step(pad1_reg, p1u, p1d);
        pad2_next = pad_step(pad2_reg, p2u, p2d);
        if (miss_l || miss_r) begin
          scorer_next = miss_r;
        end else begin
          if (hit_l) begin
            ball_x_next = HIT_L_X;
            dx_next     = 1'b1;
          end else if (hit_r) begin
            ball_x_next = HIT_R_X;
            dx_next     = 1'b0;
          end else begin
            ball_x_next = nx[10:0];
          end
          if (!dy_reg && ball_y_reg < 11'(BALL_SPD)) begin
            ball_y_next = '0;
            dy_next     = 1'b1;
          end else if (dy_reg && ny >= K_YMAX) begin
            ball_y_next = WALL_B_Y;
            dy_next     = 1'b0;
          end else begin
            ball_y_next = ny[10:0];
          end
        end
      end
      S_POINT: begin
        if (scorer_reg) begin
          if (score1_reg < WIN) score1_next = score1_reg + 4'd1;
        end else begin
          if (score2_reg < WIN) score2_next = score2_reg + 4'd1;
        end
        if (!point_wins) begin
          count_next  = '0;
          ball_x_next = BALL_X0;
          ball_y_next = BALL_Y0;
          dx_next     = scorer_reg;  // serve toward the player who lost the point
          dy_next     = !dy_reg;
        end
      end
      S_OVER: if (start_rise) begin
        score1_next = '0;
        score2_next = '0;
        pad1_next   = PAD_Y0;
        pad2_next   = PAD_Y0;
        dx_next     = 1'b1;
        count_next  = '0;
        ball_x_next = BALL_X0;
        ball_y_next = BALL_Y0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg     <= '0;
      ball_x_reg    <= BALL_X0;
      ball_y_reg    <= BALL_Y0;
      pad1_reg      <= PAD_Y0;
      pad2_reg      <= PAD_Y0;
      score1_reg    <= '0;
      score2_reg    <= '0;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      scorer_reg    <= 1'b0;
      vs_q1_reg     <= 1'b0;
      vs_q2_reg     <= 1'b0;
      frame_upd_reg <= 1'b0;
      btn_s1_reg    <= '0;
      btn_s2_reg    <= '0;
      start_q_reg   <= 1'b0;
    end else begin
      count_reg     <= count_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      pad1_reg      <= pad1_next;
      pad2_reg      <= pad2_next;
      score1_reg    <= score1_next;
      score2_reg    <= score2_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      scorer_reg    <= scorer_next;
      vs_q1_reg     <= vsync;
      vs_q2_reg     <= vs_q1_reg;
      frame_upd_reg <= tick;
      btn_s1_reg    <= {start, p2_dn, p2_up, p1_dn, p1_up};
      btn_s2_reg    <= btn_s1_reg;
      start_q_reg   <= btn_s2_reg[4];
    end
  end

  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign pad1_y    = pad1_reg;
  assign pad2_y    = pad2_reg;
  assign score1    = score1_reg;
  assign score2    = score2_reg;
  assign state     = state_reg;
  assign frame_upd = frame_upd_reg;

endmodule
